// File: rtl/fp_accum_issuer.sv
// Accumulating initiator for a sequential FP32 adder with a start/done handshake.
// Sums each in_last-delimited operand group and returns the total with an operand count.
module fp_accum_issuer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_sub,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [31:0]       acc_q;
  logic [CNT_W-1:0]  count_q;
  logic              last_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              in_ready_q, out_valid_q, add_start_q, out_err_q;
  logic [31:0]       add_a_q, add_b_q;
  logic              add_sub_q;
  logic              transfer, timeout;

  assign transfer = in_valid & in_ready_q;
  // Abort so that OUT begins exactly TIMEOUT cycles after the start pulse.
  assign timeout  = (wait_cnt_q == WAIT_W'(TIMEOUT - 2));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT: begin
        if (transfer) begin
          if (count_q == '0) state_d = in_last ? OUT : ACCEPT;
          else               state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (add_done)     state_d = last_q ? OUT : ACCEPT;
        else if (timeout) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCEPT;
      acc_q       <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      wait_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      add_start_q <= 1'b0;
      out_err_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_sub_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Handshake outputs are registered copies of the next state.
      in_ready_q  <= (state_d == ACCEPT);
      out_valid_q <= (state_d == OUT);
      add_start_q <= (state_d == ISSUE);
      case (state_q)
        ACCEPT: begin
          if (transfer) begin
            last_q  <= in_last;
            count_q <= (count_q == '1) ? count_q : count_q + CNT_W'(1);
            if (count_q == '0) begin
              acc_q <= {in_data[31] ^ in_sub, in_data[30:0]};
            end else begin
              add_a_q   <= acc_q;
              add_b_q   <= in_data;
              add_sub_q <= in_sub;
            end
          end
        end
        ISSUE: wait_cnt_q <= '0;
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (add_done)     acc_q     <= add_sum;
          else if (timeout) out_err_q <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            acc_q     <= '0;
            count_q   <= '0;
            out_err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_sub   = add_sub_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_fp_accum_issuer.sv
// Bench for fp_accum_issuer: 6-cycle adder model on integer-valued FP32 operands,
// directed scenarios followed by randomized groups checked against a signed-integer sum.
module tb_fp_accum_issuer;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready;
  logic             add_start, add_sub;
  logic [31:0]      add_a, add_b;
  logic [31:0]      add_sum = '0;
  logic             add_done = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_accum_issuer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_sum(add_sum), .add_done(add_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_err(out_err)
  );

  // Exact FP32 encoding of small integers.
  function automatic logic [31:0] enc(input int v);
    int m, p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h7fffff);
    return r;
  endfunction

  function automatic int dec(input logic [31:0] f);
    int e, m;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = int'({1'b1, f[22:0]}) >> (23 - (e - 127));
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
    return enc(dec(a) + (s ? -dec(b) : dec(b)));
  endfunction

  // Adder model: done pulse six cycles after the start pulse; never reset, so it can fire late.
  int unsigned cyc = 0;
  int unsigned n_start = 0;
  int unsigned start_cyc = 0;
  logic        sub_at_start = 1'b0;
  int          ad_cnt = 0;
  bit          adder_dead = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    add_done <= 1'b0;
    if (add_start) begin
      n_start      <= n_start + 1;
      start_cyc    <= cyc;
      sub_at_start <= add_sub;
      if (!adder_dead) ad_cnt <= 5;
    end else if (ad_cnt > 0) begin
      ad_cnt <= ad_cnt - 1;
      if (ad_cnt == 1) begin
        add_done <= 1'b1;
        add_sum  <= fadd(add_a, add_b, add_sub);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("send_bound", {127'b0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) check("out_bound", {127'b0, out_valid}, 128'd1);
  endtask

  task automatic take(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned s0;
    int          n, v, val, sum;
    bit          s, stable;

    repeat (2) @(negedge clk);
    check("reset_outputs", {in_ready, out_valid, add_start, add_sub, out_err, add_a, add_b,
                            out_data, out_count}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {127'b0, in_ready}, 128'd1);

    // 1.0 + 2.0 + 3.0
    s0 = n_start;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b1);
    wait_out();
    check("sum123_data", 128'(out_data), 128'h40C00000);
    check("sum123_count", 128'(out_count), 128'd3);
    check("sum123_err", 128'(out_err), 128'd0);
    check("sum123_starts", 128'(n_start - s0), 128'd2);
    take(0);

    // Single negated operand bypasses the adder
    s0 = n_start;
    send(32'h3F800000, 1'b1, 1'b1);
    check("single_valid_next", {127'b0, out_valid}, 128'd1);
    check("single_data", 128'(out_data), 128'hBF800000);
    check("single_count", 128'(out_count), 128'd1);
    check("single_no_start", 128'(n_start - s0), 128'd0);
    take(0);

    // 3.0 - 1.0, then hold the result for five cycles
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b1);
    wait_out();
    check("sub_flag_at_start", {127'b0, sub_at_start}, 128'd1);
    check("sub_data", 128'(out_data), 128'h40000000);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 32'h40000000 || out_count !== 8'd2 ||
          in_ready !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", {127'b0, stable}, 128'd1);
    take(0);
    check("release_ready", {127'b0, in_ready}, 128'd1);
    check("release_valid", {127'b0, out_valid}, 128'd0);
    check("release_acc", 128'(out_data), 128'd0);

    // Adder never answers
    adder_dead = 1'b1;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b1);
    wait_out();
    check("timeout_latency", 128'(cyc - start_cyc), 128'(TIMEOUT));
    check("timeout_err", 128'(out_err), 128'd1);
    check("timeout_data", 128'(out_data), 128'h3F800000);
    check("timeout_count", 128'(out_count), 128'd2);
    take(1);
    check("timeout_err_clear", 128'(out_err), 128'd0);
    adder_dead = 1'b0;

    // Reset while waiting; the adder's late done must be ignored
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_outputs", {in_ready, out_valid, add_start, add_sub, out_err, add_a, add_b,
                               out_data, out_count}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stable = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_data !== 32'h0) stable = 1'b0;
    end
    check("late_done_ignored", {127'b0, stable}, 128'd1);
    send(32'h40A00000, 1'b0, 1'b1);
    wait_out();
    check("post_rst_data", 128'(out_data), 128'h40A00000);
    check("post_rst_count", 128'(out_count), 128'd1);
    take(0);

    // Randomized groups against a signed integer sum
    for (int g = 0; g < 8; g++) begin
      n   = int'($urandom_range(1, 4));
      sum = 0;
      s0  = n_start;
      for (int i = 0; i < n; i++) begin
        v   = int'($urandom_range(1, 9));
        s   = 1'($urandom_range(0, 1));
        val = s ? -v : v;
        sum += val;
        send(enc(v), s, (i == n - 1));
      end
      wait_out();
      check("rand_data", 128'(out_data), 128'(enc(sum)));
      check("rand_count", 128'(out_count), 128'(n));
      check("rand_err", 128'(out_err), 128'd0);
      check("rand_starts", 128'(n_start - s0), 128'(n - 1));
      take(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
